// File: rtl/acc_bank.sv
// Bank of NREG independent WIDTH-bit accumulators with prioritised clear/step/load
// operations on one selected register per cycle, optional saturation and overflow flag.
module acc_bank #(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 4,
  parameter  bit SAT   = 1'b0,
  localparam int SELW  = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SELW-1:0]       sel,
  input  logic                  clr_en,
  input  logic                  inc_en,
  input  logic                  dec_en,
  input  logic                  write_en,
  input  logic                  alu_to_ac,
  input  logic [WIDTH-1:0]      step,
  input  logic [WIDTH-1:0]      data_in,
  input  logic [WIDTH-1:0]      alu_out,
  output logic [WIDTH-1:0]      data_out,
  output logic [NREG*WIDTH-1:0] all_out,
  output logic                  zero,
  output logic                  ovf,
  output logic [SELW-1:0]       ovf_idx
);

  logic [WIDTH-1:0] r_acc [NREG];
  logic             r_ovf;
  logic [SELW-1:0]  r_ovf_idx;

  logic [WIDTH-1:0] w_cur;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_next;
  logic             w_we;
  logic             w_ovf;

  assign w_cur  = r_acc[sel];
  assign w_sum  = {1'b0, w_cur} + {1'b0, step};
  // Top bit of the extended difference is the borrow (step > current value).
  assign w_diff = {1'b0, w_cur} - {1'b0, step};

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    w_next = w_cur;
    w_we   = 1'b0;
    w_ovf  = 1'b0;
    if (clr_en) begin
      w_next = '0;
      w_we   = 1'b1;
    end else if (inc_en) begin
      w_we   = 1'b1;
      w_ovf  = w_sum[WIDTH];
      w_next = (SAT && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
    end else if (dec_en) begin
      w_we   = 1'b1;
      w_ovf  = w_diff[WIDTH];
      w_next = (SAT && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
    end else if (write_en) begin
      w_next = data_in;
      w_we   = 1'b1;
    end else if (alu_to_ac) begin
      w_next = alu_out;
      w_we   = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank is a handful of flops, not a RAM, so each entry is reset explicitly.
      for (int i = 0; i < NREG; i++) begin
        r_acc[i] <= '0;
      end
      r_ovf     <= 1'b0;
      r_ovf_idx <= '0;
    end else begin
      if (w_we) begin
        r_acc[sel] <= w_next;
      end
      r_ovf <= w_ovf;
      if (w_ovf) begin
        r_ovf_idx <= sel;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_all
    assign all_out[g*WIDTH +: WIDTH] = r_acc[g];
  end

  assign data_out = w_cur;
  assign zero     = (w_cur == '0);
  assign ovf      = r_ovf;
  assign ovf_idx  = r_ovf_idx;

endmodule

// File: doc/acc_bank.md
# acc_bank

Parametrised accumulator bank: the successor to the datapath's single 16-bit accumulator. It holds NREG independent WIDTH-bit accumulators. One addressed register per cycle can be cleared, stepped up or down by a programmable amount, loaded from the data bus, or loaded from the ALU result. It reports zero and carry/borrow status, and it can wrap or saturate. It sits between the memory data bus and the ALU, and also serves as the pixel/row address counters of the downsampling loop.

## Interface
Parameters:
- WIDTH, 16, bit width of each accumulator
- NREG, 4, number of accumulators (≥2, power of two)
- SAT, 0, 0 = modular wrap on overflow/underflow, 1 = clamp at 2^WIDTH−1 / 0

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- sel  in  log2(NREG)  index of the register operated on and read out
- clr_en  in  1  clear selected register to 0
- inc_en  in  1  add step to selected register
- dec_en  in  1  subtract step from selected register
- write_en  in  1  load data_in into selected register
- alu_to_ac  in  1  load alu_out into selected register
- step  in  WIDTH  unsigned step for inc/dec
- data_in  in  WIDTH  memory data bus
- alu_out  in  WIDTH  ALU result
- data_out  out  WIDTH  contents of register sel (combinational mux of registered state)
- all_out  out  NREG*WIDTH  all registers, reg i at [i*WIDTH +: WIDTH]
- zero  out  1  data_out == 0 (combinational)
- ovf  out  1  registered; 1 for one cycle after an inc/dec that overflowed/underflowed
- ovf_idx  out  log2(NREG)  registered; index that produced ovf, holds last value

## Operation
- Priority, highest first: rst > clr_en > inc_en > dec_en > write_en > alu_to_ac. Only the highest asserted op acts; the rest are ignored that cycle.
- Only register sel changes per cycle. All other registers hold.
- inc: compute a WIDTH+1 sum r+step.
  - Carry set, SAT=0: result is the low WIDTH bits.
  - Carry set, SAT=1: result is all ones.
- dec: compute r−step.
  - Borrow (step > r), SAT=0: result is the modular value.
  - Borrow, SAT=1: result is 0.
- ovf is set next cycle iff the winning op was inc/dec and produced a carry/borrow, in either SAT mode. Otherwise ovf=0.
- ovf_idx loads sel whenever ovf is set; it holds otherwise.
- step=0 with inc/dec: register unchanged, ovf=0.
- write/alu load: the value is stored verbatim; ovf=0.
- sel out of range cannot occur (NREG is a power of two).
- No operation asserted: all state holds, ovf=0.

## Timing
- Reset values: every register 0, ovf=0, ovf_idx=0, hence data_out=0 and zero=1.
- rst asserted at a clock edge overrides any op in the same cycle. Op enables that are high during reset have no effect.
- Write latency is 1 cycle: an op sampled at edge N is visible on data_out/all_out after edge N.
- data_out and zero follow sel combinationally within the same cycle, with no extra latency.
- ovf is a single-cycle pulse aligned with the updated register value. Back-to-back overflowing ops give a continuous high ovf, with ovf_idx updated each cycle.
- Read-modify-write of the same register on consecutive cycles uses the updated value, with no hazard. For example, inc on two consecutive cycles gives +2·step.

## Test plan
- Reset/idle: assert rst for 2 cycles with inc_en=1 → all_out=0, zero=1, ovf=0. Deassert with no ops for 5 cycles → state unchanged.
- Priority and isolation (WIDTH=16, NREG=4): sel=2, write_en=1, data_in=0x1234 → reg2=0x1234, other regs 0. Next cycle, inc_en=1, write_en=1, alu_to_ac=1, step=1 → reg2=0x1235. Then clr_en with inc_en → reg2=0.
- Wrap mode (SAT=0): reg1=0xFFFE, inc step=3 → reg1=0x0001, ovf=1 for exactly one cycle, ovf_idx=1. Then dec step=2 → 0xFFFF, ovf=1.
- Saturate mode (SAT=1): reg3=0xFFF0, inc step=0x20 → 0xFFFF, ovf=1. reg0=5, dec step=9 → 0, ovf=1, zero=1 with sel=0.
- Back-to-back counting: sel=0, inc_en held for 10 cycles with step=4 → reg0=40 and ovf never set. Toggling sel each cycle between 0 and 1 with inc step=1 for 6 cycles → reg0=3, reg1=3.
- Reset mid-operation: reg2=0x00FF, then inc_en with rst=1 in the same cycle → all registers 0, ovf=0. The following inc step=1 → reg2=1.
